// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute-stage bus and selects the write-back value (ALU result or load data).
// Optional macro MEM_RDATA_HOLD_EN keeps load data stable across write-back stalls.
module mem_stage #(
   parameter int EXE_TO_MEM_BUS_WD = 79,
   parameter int MEM_TO_WB_BUS_WD  = 70,
   parameter int MEM_TO_BY_BUS_WD  = 39
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
   input  logic                         EXE_to_MEM_valid,
   output logic                         MEM_allow_in,
   input  logic                         WB_allow_in,
   output logic                         MEM_to_WB_valid,
   output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
   output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus,
   input  logic [31:0]                  data_ram_r_data
);

   // Handshake: an instruction moves on an edge where the sender's valid and the
   // receiver's allow_in are both high; allow_in opens when the stage is empty or draining.
   localparam logic MEM_READY_GO = 1'b1;

   logic                         mem_valid;
   logic [EXE_TO_MEM_BUS_WD-1:0] mem_bus_r;

   logic [2:0]  wdata_valid_stage;
   logic        rf_we;
   logic        sel_rf_w_data;
   logic        is_byte;
   logic [3:0]  byte_en;
   logic [4:0]  rf_waddr;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [31:0] rdata_eff;
   logic [7:0]  byte_sel;
   logic [31:0] load_val;
   logic [31:0] rf_wdata;
   logic        mem_wdata_valid;
   logic        unused_stage_bit;

   assign MEM_allow_in    = ~mem_valid | (MEM_READY_GO & WB_allow_in);
   assign MEM_to_WB_valid = mem_valid & MEM_READY_GO;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         mem_bus_r <= '0;
      end else begin
         if (MEM_allow_in)
            mem_valid <= EXE_to_MEM_valid;
         if (EXE_to_MEM_valid & MEM_allow_in)
            mem_bus_r <= EXE_to_MEM_bus;
      end
   end

   assign {wdata_valid_stage, rf_we, sel_rf_w_data, is_byte, byte_en,
           rf_waddr, alu_result, pc} = mem_bus_r;
   assign unused_stage_bit = wdata_valid_stage[2];

`ifdef MEM_RDATA_HOLD_EN
   // The RAM is re-driven by the stalled execute stage, so the first-cycle data is captured here.
   logic [31:0] hold_data;
   logic        hold_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (mem_valid & WB_allow_in) begin
         hold_valid <= 1'b0;
      end else if (mem_valid & ~hold_valid & ~WB_allow_in) begin
         hold_data  <= data_ram_r_data;
         hold_valid <= 1'b1;
      end
   end

   assign rdata_eff = hold_valid ? hold_data : data_ram_r_data;
`else
   assign rdata_eff = data_ram_r_data;
`endif

   always_comb begin
      byte_sel = 8'h00;
      case (byte_en)
         4'b0001: byte_sel = rdata_eff[7:0];
         4'b0010: byte_sel = rdata_eff[15:8];
         4'b0100: byte_sel = rdata_eff[23:16];
         4'b1000: byte_sel = rdata_eff[31:24];
         default: byte_sel = 8'h00;
      endcase
   end

   assign load_val = is_byte ? {{24{byte_sel[7]}}, byte_sel} : rdata_eff;
   assign rf_wdata = sel_rf_w_data ? load_val : alu_result;

   assign mem_wdata_valid = mem_valid & MEM_READY_GO &
                            (wdata_valid_stage[0] | wdata_valid_stage[1]);

   assign MEM_to_WB_bus = {rf_we, rf_waddr, rf_wdata, pc};
   assign MEM_to_BY_bus = {rf_waddr, rf_wdata, mem_wdata_valid, rf_we};

endmodule
